last_tag_fifo: RTL and testbench

//  Parametrised synchronous show-ahead FIFO. Each entry holds DATA_W data bits plus a
//  per-entry LAST tag. Both sides use valid/ready handshakes.

---
 rtl/last_tag_fifo_if.sv | 38 +++
 rtl/last_tag_fifo.sv | 101 ++++++++++
 tb/tb_last_tag_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/last_tag_fifo_if.sv
// Stream handshake bundle for last_tag_fifo: write side (s_*) and read side (m_*).
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface last_tag_fifo_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] s_data_i;
  logic              s_last_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic              m_valid_o;
  logic              m_ready_i;

  modport slave (
    input  s_data_i,
    input  s_last_i,
    input  s_valid_i,
    output s_ready_o,
    output m_data_o,
    output m_last_o,
    output m_valid_o,
    input  m_ready_i
  );

  modport master (
    output s_data_i,
    output s_last_i,
    output s_valid_i,
    input  s_ready_o,
    input  m_data_o,
    input  m_last_o,
    input  m_valid_o,
    output m_ready_i
  );

endinterface

// File: rtl/last_tag_fifo.sv
// Show-ahead FIFO with a per-entry LAST tag. Tracks occupancy and the number of queued
// LAST tags so upstream logic can tell whether a complete packet is buffered.
// Status is derived only from registered pointers; there is no push-to-pop bypass and
// no combinational path from m_ready_i to s_ready_o.
// The interface instance must use the same DATA_W as this module.
module last_tag_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = DEPTH - 2,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  last_tag_fifo_if.slave bus,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] last_cnt_o,
  output logic          any_last_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o
);

  localparam int unsigned AW = CW - 1;
  localparam logic [CW-1:0] AFullTh = CW'(AFULL_TH);

  // Entry layout: {last, data}. Not reset; only the pointers qualify contents.
  logic [DATA_W:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_last_cnt;

  logic [CW-1:0] w_last_cnt_nxt;
  logic [CW-1:0] w_count;
  logic [DATA_W:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_head_last;

  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_last = w_head[DATA_W];

  // A flush cycle swallows both handshakes.
  assign w_push = bus.s_valid_i & ~w_full & ~flush_i;
  assign w_pop  = bus.m_ready_i & ~w_empty & ~flush_i;

  // Next LAST-tag count: a tagged push and a tagged pop in the same cycle cancel.
  always_comb begin
    w_last_cnt_nxt = r_last_cnt;
    unique case ({w_push & bus.s_last_i, w_pop & w_head_last})
      2'b10:   w_last_cnt_nxt = r_last_cnt + CW'(1);
      2'b01:   w_last_cnt_nxt = r_last_cnt - CW'(1);
      default: w_last_cnt_nxt = r_last_cnt;
    endcase
  end

  // Pointer and tag-count state; async reset and sync flush both return to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_cnt <= '0;
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
      r_last_cnt <= w_last_cnt_nxt;
    end
  end

  // Storage write on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {bus.s_last_i, bus.s_data_i};
  end

  // Handshake outputs; head data is forced to zero when nothing is stored.
  assign bus.s_ready_o = ~w_full;
  assign bus.m_valid_o = ~w_empty;
  assign bus.m_data_o  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign bus.m_last_o  = ~w_empty & w_head_last;

  // Status outputs.
  assign count_o       = w_count;
  assign last_cnt_o    = r_last_cnt;
  assign any_last_o    = (r_last_cnt != '0);
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = (w_count >= AFullTh);

endmodule

// File: tb/tb_last_tag_fifo.sv
// Bench for last_tag_fifo: directed scenarios plus random traffic. A queue-based model
// tracks stored entries; a scoreboard queue is filled on committed pushes and drained by
// a negedge monitor whenever the DUT completes a pop.
module tb_last_tag_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 8;
  localparam int unsigned AF = DP - 2;
  localparam int unsigned CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic [CW-1:0] count_o;
  logic [CW-1:0] last_cnt_o;
  logic          any_last_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;

  last_tag_fifo_if #(.DATA_W(DW)) bus ();

  last_tag_fifo #(
    .DATA_W  (DW),
    .DEPTH   (DP),
    .AFULL_TH(AF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .bus          (bus),
    .count_o      (count_o),
    .last_cnt_o   (last_cnt_o),
    .any_last_o   (any_last_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .almost_full_o(almost_full_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: entries currently stored, as {last, data}.
  bit [8:0] mdl_q[$];
  // Scoreboard: entries expected to emerge, popped by the monitor.
  bit [8:0] exp_q[$];

  // Handshake decided for the upcoming edge, committed to the model after it.
  bit       p_push = 1'b0;
  bit       p_pop = 1'b0;
  bit       p_flush = 1'b0;
  bit [8:0] p_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_last_cnt();
    int n = 0;
    foreach (mdl_q[i]) if (mdl_q[i][8]) n++;
    return n;
  endfunction

  task automatic commit();
    if (p_flush) begin
      mdl_q.delete();
      exp_q.delete();
    end else begin
      if (p_pop) void'(mdl_q.pop_front());
      if (p_push) begin
        mdl_q.push_back(p_word);
        exp_q.push_back(p_word);
      end
    end
  endtask

  // One cycle: commit the previous handshake, then apply and decide the next one.
  task automatic drive(input bit v, input bit [7:0] d, input bit l, input bit r, input bit f);
    @(posedge clk);
    #1;
    commit();
    bus.s_valid_i = v;
    bus.s_data_i  = d;
    bus.s_last_i  = l;
    bus.m_ready_i = r;
    flush_i       = f;
    p_flush = f;
    p_push  = v && !f && (mdl_q.size() < DP);
    p_pop   = r && !f && (mdl_q.size() > 0);
    p_word  = {l, d};
  endtask

  task automatic idle_inputs();
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.s_last_i  = 1'b0;
    bus.m_ready_i = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_last_cnt"}, last_cnt_o, 0);
    check({tag, "_empty"}, empty_o, 1);
    check({tag, "_full"}, full_o, 0);
    check({tag, "_s_ready"}, bus.s_ready_o, 1);
    check({tag, "_m_valid"}, bus.m_valid_o, 0);
    check({tag, "_any_last"}, any_last_o, 0);
    check({tag, "_almost_full"}, almost_full_o, 0);
    check({tag, "_m_data"}, bus.m_data_o, 0);
    check({tag, "_m_last"}, bus.m_last_o, 0);
  endtask

  // Monitor: status against the model every cycle, pops against the scoreboard.
  always @(negedge clk) begin
    int n;
    int nl;
    bit [8:0] w;
    if (rst_n) begin
      n  = mdl_q.size();
      nl = model_last_cnt();
      check("count", count_o, n);
      check("last_cnt", last_cnt_o, nl);
      check("any_last", any_last_o, nl != 0);
      check("full", full_o, n == DP);
      check("empty", empty_o, n == 0);
      check("almost_full", almost_full_o, n >= AF);
      check("s_ready", bus.s_ready_o, n < DP);
      check("m_valid", bus.m_valid_o, n != 0);
      if (n == 0) begin
        check("empty_m_data", bus.m_data_o, 0);
        check("empty_m_last", bus.m_last_o, 0);
      end
      if (bus.m_valid_o && bus.m_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_underflow actual=data %0h expected=no entry t=%0t",
                   bus.m_data_o, $time);
        end else begin
          w = exp_q.pop_front();
          check("pop_data", bus.m_data_o, w[7:0]);
          check("pop_last", bus.m_last_o, w[8]);
        end
      end
    end
  end

  initial begin
    idle_inputs();

    // Reset values while held and right after release.
    #3;
    check_reset_outputs("in_reset");
    #9 rst_n = 1'b1;
    #1;
    check_reset_outputs("after_release");

    // Fill to full with consumer stalled; LAST on 0x13 and 0x17.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h10 + 8'(i), (i == 3) || (i == 7), 1'b0, 1'b0);
      if (i == 6) begin
        check("fill_count6", count_o, 6);
        check("fill_afull6", almost_full_o, 1);
      end
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("fill_full", full_o, 1);
    check("fill_s_ready", bus.s_ready_o, 0);
    check("fill_count8", count_o, 8);
    check("fill_last_cnt", last_cnt_o, 2);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("ninth_rejected", count_o, 8);

    // Drain in order.
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("drain_empty", empty_o, 1);
    check("drain_m_data", bus.m_data_o, 0);
    check("drain_last_cnt", last_cnt_o, 0);

    // Steady state at count 4 with push and pop every cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'($urandom), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("stream_count4", count_o, 4);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Count 5 with one LAST, then flush alongside a push of 0xAA.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h50 + 8'(i), i == 1, 1'b0, 1'b0);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    check("pre_flush_count", count_o, 5);
    check("pre_flush_last_cnt", last_cnt_o, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("flush_count", count_o, 0);
    check("flush_last_cnt", last_cnt_o, 0);
    check("flush_empty", empty_o, 1);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("flush_no_aa", bus.m_valid_o, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0, 1'b0);
    #2;
    check("pre_reset_nonempty", empty_o, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    idle_inputs();
    mdl_q.delete();
    exp_q.delete();
    p_push  = 1'b0;
    p_pop   = 1'b0;
    p_flush = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Resume normal operation.
    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 1) != 0, 8'($urandom), 1'($urandom),
            $urandom_range(0, 1) != 0, 1'b0);
    for (int i = 0; i < DP + 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("final_empty", empty_o, 1);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
